xrv1_wb_arb: RTL
================

// Module: xrv1_wb_arb
// PURPOSE
//  Writeback arbiter directly upstream of the xrv1 register file's single write port.
//  Merges results from the ALU (s0) and the LSU (s1) into one write per cycle, in age order.
//  Each source gets a one-entry holding slot; the block drives rd_w_en/rd_addr/rd_data.
//  Also provides a bypass copy of the current write and pending-register queries for hazard stall.
// PARAMETERS
//  DATA_WIDTH_P     32  width of register data
//  rf_addr_width_p  5   register index width; must match the register file
// PORTS
//  clk_i         in   1   clock, all state on posedge
//  rst_i         in   1   asynchronous, active-high reset
//  s0_valid_i    in   1   ALU result valid
//  s0_ready_o    out  1   s0 slot can accept this cycle
//  s0_addr_i     in   A   ALU destination register (A = rf_addr_width_p)
//  s0_data_i     in   D   ALU result (D = DATA_WIDTH_P)
//  s1_valid_i    in   1   LSU load result valid
//  s1_ready_o    out  1   s1 slot can accept this cycle
//  s1_addr_i     in   A   LSU destination register
//  s1_data_i     in   D   LSU load data
//  rd_w_en_o     out  1   register file write enable
//  rd_addr_o     out  A   register file write address
//  rd_data_o     out  D   register file write data
//  byp_valid_o   out  1   equals rd_w_en_o; forward to decode (the register file writes at the edge)
//  byp_addr_o    out  A   equals rd_addr_o
//  byp_data_o    out  D   equals rd_data_o
//  q0_addr_i     in   A   hazard query 0 (decode rs0)
//  q0_pend_o     out  1   q0_addr_i is held in a full slot that is not being written this cycle
//  q1_addr_i     in   A   hazard query 1 (decode rs1)
//  q1_pend_o     out  1   same rule for q1_addr_i
// BEHAVIOUR
//  - Reset: both slots empty, older_q=0, every output is 0 except sN_ready_o=1.
//  - Slot N accepts a result on sN_valid_i & sN_ready_o and captures addr/data. It is full from the next cycle.
//  - Grant: only one full -> grant it. Both full -> grant the older (older_q). If both loaded in the same cycle, grant s0.
//  - older_q: set when a slot loads while the other slot is full and not granted. That full slot becomes the older one.
//  - rd_* and byp_* are combinational from the granted slot's registers. No path from sN_valid_i.
//  - Latency: a result accepted at edge N is written into the register file at edge N+1 if it is granted immediately.
//  - The granted slot clears at the edge. sN_ready_o = !full | granted.
//    A back-to-back push on the same source therefore sustains 1 result per cycle.
//  - An ungranted full slot holds: sN_ready_o=0 and its contents stay stable until it is granted.
//  - Destination x0: the slot is granted and drained normally, but rd_w_en_o=0 and byp_valid_o=0. rd_addr/rd_data still reflect the slot.
//  - No grant (both empty): rd_w_en_o=0 and rd_addr/rd_data=0.
//  - qN_pend_o=1 iff qN_addr_i!=0 and some full, non-granted slot has a matching addr.
//    A granted match is served by byp_* instead.
//  - Same rd in both slots: age order guarantees the older value is written first and the younger one persists.
//  - Pushing into an empty slot while the other source is being granted has no interaction.
//  - A reset asserted mid-operation drops contents immediately, including any pending write. rd_w_en_o falls asynchronously.
// STRUCTURE
//  - xrv1_pkg: wb_slot_t struct {logic full; logic [A-1:0] addr; logic [D-1:0] data;}.
//  - Sub-module xrv1_wb_slot (one-entry holding register):
//    - inputs: push, push_addr, push_data, pop
//    - outputs: full, addr, data, ready
//    - instantiated twice.
//  - Top level contains the age bit, grant logic, output muxing and the two comparators per query.
// TESTING
//  - Reset then idle: rd_w_en_o=0, s0/s1_ready_o=1, q0_pend_o=0 with q0_addr_i=5.
//  - s0 push x3=0x11 at cycle 1, idle s1 -> cycle 2 rd_w_en_o=1, rd_addr_o=3, rd_data_o=0x11, byp mirrors.
//  - s0 and s1 push in the same cycle (x4=0xA, x5=0xB):
//    - next cycle: write x4=0xA, s1_ready_o=0, q0_pend_o=1 for q0_addr_i=5
//    - the cycle after: write x5=0xB
//  - s1 loads x6=1 while s0 is held; s0 pushes x6=2 after s1's slot is full:
//    - writes occur in order x6=1 then x6=2, matching the loaded order
//  - s0 streams x1..x8 on 8 consecutive cycles with s1 idle -> 8 consecutive writes, s0_ready_o held 1.
//  - Push to x0 with data 0xFFFF -> slot drains in 1 cycle with rd_w_en_o=0 and q0_pend_o=0 for q0_addr_i=0.
//  - rst_i asserted while both slots are full -> rd_w_en_o drops the same cycle.
//    After release: no write of the old contents, both ready=1.

Source files
------------

// File: rtl/xrv1_pkg.sv
// Shared types for the xrv1 writeback path: one holding-slot entry
// (valid flag, destination register, result data).
package xrv1_pkg;
    localparam int XRV1_DATA_W = 32;
    localparam int XRV1_ADDR_W = 5;

    typedef struct packed {
        logic                   full;
        logic [XRV1_ADDR_W-1:0] addr;
        logic [XRV1_DATA_W-1:0] data;
    } wb_slot_t;
endpackage

// File: rtl/xrv1_wb_slot.sv
// One-entry holding register for a writeback source. A push overrides a
// pop in the same cycle so a granted slot can refill back to back.
module xrv1_wb_slot
    import xrv1_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [XRV1_ADDR_W-1:0] push_addr,
    input  logic [XRV1_DATA_W-1:0] push_data,
    input  logic                   pop,
    output logic                   full,
    output logic [XRV1_ADDR_W-1:0] addr,
    output logic [XRV1_DATA_W-1:0] data,
    output logic                   ready
);
    wb_slot_t slot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else if (push) begin
            slot_q <= '{full: 1'b1, addr: push_addr, data: push_data};
        end else if (pop) begin
            slot_q.full <= 1'b0;
        end
    end

    assign full  = slot_q.full;
    assign addr  = slot_q.addr;
    assign data  = slot_q.data;
    assign ready = !slot_q.full || pop;
endmodule

// File: rtl/xrv1_wb_arb.sv
// Writeback arbiter: merges ALU (s0) and LSU (s1) results into the single
// register-file write port in age order, with bypass and hazard queries.
module xrv1_wb_arb
    import xrv1_pkg::*;
#(
    parameter int DATA_WIDTH_P    = XRV1_DATA_W,
    parameter int rf_addr_width_p = XRV1_ADDR_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       s0_valid_i,
    output logic                       s0_ready_o,
    input  logic [rf_addr_width_p-1:0] s0_addr_i,
    input  logic [DATA_WIDTH_P-1:0]    s0_data_i,
    input  logic                       s1_valid_i,
    output logic                       s1_ready_o,
    input  logic [rf_addr_width_p-1:0] s1_addr_i,
    input  logic [DATA_WIDTH_P-1:0]    s1_data_i,
    output logic                       rd_w_en_o,
    output logic [rf_addr_width_p-1:0] rd_addr_o,
    output logic [DATA_WIDTH_P-1:0]    rd_data_o,
    output logic                       byp_valid_o,
    output logic [rf_addr_width_p-1:0] byp_addr_o,
    output logic [DATA_WIDTH_P-1:0]    byp_data_o,
    input  logic [rf_addr_width_p-1:0] q0_addr_i,
    output logic                       q0_pend_o,
    input  logic [rf_addr_width_p-1:0] q1_addr_i,
    output logic                       q1_pend_o
);
    logic                       full0, full1, gnt0, gnt1, push0, push1;
    logic [rf_addr_width_p-1:0] addr0, addr1;
    logic [DATA_WIDTH_P-1:0]    data0, data1;
    logic                       older_q;  // 0: s0 holds the older entry, 1: s1

    assign push0 = s0_valid_i && s0_ready_o;
    assign push1 = s1_valid_i && s1_ready_o;

    xrv1_wb_slot u_slot0 (
        .clk(clk_i), .rst(rst_i), .push(push0), .push_addr(s0_addr_i),
        .push_data(s0_data_i), .pop(gnt0), .full(full0), .addr(addr0),
        .data(data0), .ready(s0_ready_o)
    );

    xrv1_wb_slot u_slot1 (
        .clk(clk_i), .rst(rst_i), .push(push1), .push_addr(s1_addr_i),
        .push_data(s1_data_i), .pop(gnt1), .full(full1), .addr(addr1),
        .data(data1), .ready(s1_ready_o)
    );

    assign gnt0 = full0 && (!full1 || !older_q);
    assign gnt1 = full1 && (!full0 ||  older_q);

    // A slot that loads next to a held (full, ungranted) entry is younger;
    // simultaneous loads tie-break to s0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            older_q <= 1'b0;
        end else if (push0 && push1) begin
            older_q <= 1'b0;
        end else if (push1 && full0 && !gnt0) begin
            older_q <= 1'b0;
        end else if (push0 && full1 && !gnt1) begin
            older_q <= 1'b1;
        end
    end

    always_comb begin
        rd_addr_o = '0;
        rd_data_o = '0;
        if (gnt0) begin
            rd_addr_o = addr0;
            rd_data_o = data0;
        end else if (gnt1) begin
            rd_addr_o = addr1;
            rd_data_o = data1;
        end
    end

    // x0 is drained like any other slot but never written.
    assign rd_w_en_o   = (gnt0 || gnt1) && (rd_addr_o != '0);
    assign byp_valid_o = rd_w_en_o;
    assign byp_addr_o  = rd_addr_o;
    assign byp_data_o  = rd_data_o;

    assign q0_pend_o = (q0_addr_i != '0) &&
                       ((full0 && !gnt0 && addr0 == q0_addr_i) ||
                        (full1 && !gnt1 && addr1 == q0_addr_i));
    assign q1_pend_o = (q1_addr_i != '0) &&
                       ((full0 && !gnt0 && addr0 == q1_addr_i) ||
                        (full1 && !gnt1 && addr1 == q1_addr_i));
endmodule
